// File: rtl/fc_bias_add_sched_pkg.sv
// Shared definitions for the fully-connected bias-add scheduler:
// the FSM state encoding and the default layer geometry constants.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_BIAS,
        WAIT_ACC,
        OUT
    } fc_bias_state_e;

    localparam int FC_LENGTH      = 4;
    localparam int FC_BIAS_ADDR_W = 10;
    localparam int FC_MAX_TILES   = 256;

    // Bias read latency is at most 7 cycles, so a 3-bit counter covers it.
    localparam int FC_LAT_W       = 3;

endpackage

// File: rtl/fc_bias_add_sched_if.sv
// Signal bundle between the bias-add scheduler and its surroundings:
// layer control, bias memory read port, MAC accumulator handshake and
// the downstream result handshake.
// When FC_BIAS_SCHED_PERF_EN is defined the bundle also carries the
// 32-bit stall_cycles performance counter.
interface fc_bias_add_sched_if #(
    parameter int TILE_W      = 9,
    parameter int BIAS_ADDR_W = 10
);

    logic                   start;
    logic [TILE_W-1:0]      cfg_num_tiles;
    logic [BIAS_ADDR_W-1:0] cfg_bias_base;
    logic                   busy;
    logic                   done;
    logic                   bias_rd_en;
    logic [BIAS_ADDR_W-1:0] bias_rd_addr;
    logic                   acc_valid;
    logic                   acc_ready;
    logic                   add_ena;
    logic                   out_valid;
    logic                   out_ready;
    logic [TILE_W-1:0]      out_tile_idx;
`ifdef FC_BIAS_SCHED_PERF_EN
    logic [31:0]            stall_cycles;
`endif

`ifdef FC_BIAS_SCHED_PERF_EN
    // Environment side: issues layers, supplies accumulators, sinks results.
    modport master (
        output start, cfg_num_tiles, cfg_bias_base, acc_valid, out_ready,
        input  busy, done, bias_rd_en, bias_rd_addr, acc_ready, add_ena,
               out_valid, out_tile_idx, stall_cycles
    );

    // Scheduler side.
    modport slave (
        input  start, cfg_num_tiles, cfg_bias_base, acc_valid, out_ready,
        output busy, done, bias_rd_en, bias_rd_addr, acc_ready, add_ena,
               out_valid, out_tile_idx, stall_cycles
    );
`else
    // Environment side: issues layers, supplies accumulators, sinks results.
    modport master (
        output start, cfg_num_tiles, cfg_bias_base, acc_valid, out_ready,
        input  busy, done, bias_rd_en, bias_rd_addr, acc_ready, add_ena,
               out_valid, out_tile_idx
    );

    // Scheduler side.
    modport slave (
        input  start, cfg_num_tiles, cfg_bias_base, acc_valid, out_ready,
        output busy, done, bias_rd_en, bias_rd_addr, acc_ready, add_ena,
               out_valid, out_tile_idx
    );
`endif

endinterface

// File: rtl/fc_bias_add_sched_lat_counter.sv
// Loadable down-counter with a terminal flag. Used to time out the bias
// memory read latency: loaded with the latency, decremented once per wait
// cycle, and terminal is raised while the count sits at 1 (last wait cycle).
module fc_lat_counter
    import fc_pkg::*;
#(
    parameter int W = FC_LAT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         terminal
);

    logic [W-1:0] count;

    // Count register: load wins over decrement, and the count never wraps below 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == W'(1));

endmodule

// File: rtl/fc_bias_add_sched.sv
// Bias-add sequencer for one FC engine. Walks the layer tile by tile:
// read the bias word, wait out the memory latency, accept one accumulated
// vector from the MAC array (pulsing the bias adder enable), then present
// the registered sum downstream with valid/ready backpressure.
// Optional feature: FC_BIAS_SCHED_PERF_EN adds a saturating stall counter.
module fc_bias_add_sched
    import fc_pkg::*;
#(
    parameter int LENGTH      = FC_LENGTH,
    parameter int BIAS_RD_LAT = 1,
    parameter int MAX_TILES   = FC_MAX_TILES,
    parameter int TILE_W      = $clog2(MAX_TILES) + 1,
    parameter int BIAS_ADDR_W = FC_BIAS_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    fc_bias_add_sched_if.slave    bus
);

    // Reject parameter sets the counters and tile index cannot represent.
    if (LENGTH < 1 || BIAS_RD_LAT < 1 || BIAS_RD_LAT > 7 ||
        MAX_TILES < 1 || MAX_TILES >= (1 << TILE_W)) begin : g_param_check
        $error("fc_bias_add_sched: illegal parameter combination");
    end

    localparam logic [TILE_W-1:0]   MAX_T   = TILE_W'(MAX_TILES);
    localparam logic [FC_LAT_W-1:0] LAT_VAL = FC_LAT_W'(BIAS_RD_LAT);

    fc_bias_state_e          state;
    fc_bias_state_e          state_nxt;
    logic [TILE_W-1:0]       tile_idx;
    logic [TILE_W-1:0]       num_tiles_q;
    logic [BIAS_ADDR_W-1:0]  base_q;
    logic                    done_q;
    logic [TILE_W-1:0]       tiles_clamped;
    logic                    last_tile;
    logic                    lat_load;
    logic                    lat_dec;
    logic                    lat_term;

    assign tiles_clamped = (bus.cfg_num_tiles > MAX_T) ? MAX_T : bus.cfg_num_tiles;
    assign last_tile     = (tile_idx == (num_tiles_q - 1'b1));

    fc_lat_counter #(
        .W (FC_LAT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (lat_load),
        .load_val (LAT_VAL),
        .dec      (lat_dec),
        .terminal (lat_term)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and latency counter control.
    always_comb begin
        state_nxt = state;
        lat_load  = 1'b0;
        lat_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (tiles_clamped != '0)) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                lat_load  = 1'b1;
                state_nxt = WAIT_BIAS;
            end
            WAIT_BIAS: begin
                lat_dec = 1'b1;
                if (lat_term) begin
                    state_nxt = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (bus.acc_valid) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_nxt = last_tile ? IDLE : FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Layer configuration, tile index and the end-of-layer done pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            num_tiles_q <= '0;
            base_q      <= '0;
            tile_idx    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (tiles_clamped != '0) begin
                            num_tiles_q <= tiles_clamped;
                            base_q      <= bus.cfg_bias_base;
                            tile_idx    <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (last_tile) begin
                            done_q <= 1'b1;
                        end else begin
                            tile_idx <= tile_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FC_BIAS_SCHED_PERF_EN
    logic [31:0] stall_q;

    // Count cycles lost waiting on the MAC array or on downstream, saturating.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if ((state == IDLE) && bus.start) begin
            stall_q <= '0;
        end else if ((((state == WAIT_ACC) && !bus.acc_valid) ||
                      ((state == OUT) && !bus.out_ready)) && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;
    assign bus.bias_rd_en   = (state == FETCH);
    assign bus.bias_rd_addr = base_q + BIAS_ADDR_W'(tile_idx);
    assign bus.acc_ready    = (state == WAIT_ACC);
    assign bus.add_ena      = bus.acc_valid && (state == WAIT_ACC);
    assign bus.out_valid    = (state == OUT);
    assign bus.out_tile_idx = tile_idx;

endmodule

// File: tb/tb_fc_bias_add_sched.sv
// Self-checking bench for fc_bias_add_sched. Two instances: one with a
// 1-cycle bias memory and one with a 3-cycle bias memory. Expected bias
// addresses and output tile indices are queued when a layer is issued and
// popped by a monitor on every read strobe / output handshake.
// Honours FC_BIAS_SCHED_PERF_EN for the stall counter checks.
module tb_fc_bias_add_sched;

    logic clk;
    logic rstn;

    fc_bias_add_sched_if #(.TILE_W(9), .BIAS_ADDR_W(10)) bus1 ();
    fc_bias_add_sched_if #(.TILE_W(9), .BIAS_ADDR_W(10)) bus3 ();

    fc_bias_add_sched #(.BIAS_RD_LAT(1)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    fc_bias_add_sched #(.BIAS_RD_LAT(3)) u_dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr1[$];
    logic [31:0] exp_tile1[$];
    logic [31:0] exp_addr3[$];
    logic [31:0] exp_tile3[$];

    int busy_cnt1 = 0;
    int add_cnt1  = 0;
    int done_cnt1 = 0;
    int hs_cnt1   = 0;
    int rd_cnt1   = 0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_unexpected(input string name, input logic [31:0] actual);
        n_checks++;
        $display("[TB] FAIL %s: got event with value 0x%0h, expected no event", name, actual);
    endtask

    // Monitor: pops the scoreboard on every read strobe and output handshake.
    always @(negedge clk) begin
        if (bus1.bias_rd_en) begin
            rd_cnt1++;
            if (exp_addr1.size() == 0) check_unexpected("bias_rd1_extra", 32'(bus1.bias_rd_addr));
            else check_output("bias_rd_addr1", 32'(bus1.bias_rd_addr), exp_addr1.pop_front());
        end
        if (bus1.out_valid && bus1.out_ready) begin
            hs_cnt1++;
            if (exp_tile1.size() == 0) check_unexpected("out_hs1_extra", 32'(bus1.out_tile_idx));
            else check_output("out_tile_idx1", 32'(bus1.out_tile_idx), exp_tile1.pop_front());
        end
        if (bus1.busy)    busy_cnt1++;
        if (bus1.add_ena) add_cnt1++;
        if (bus1.done)    done_cnt1++;
        if (bus3.bias_rd_en) begin
            if (exp_addr3.size() == 0) check_unexpected("bias_rd3_extra", 32'(bus3.bias_rd_addr));
            else check_output("bias_rd_addr3", 32'(bus3.bias_rd_addr), exp_addr3.pop_front());
        end
        if (bus3.out_valid && bus3.out_ready) begin
            if (exp_tile3.size() == 0) check_unexpected("out_hs3_extra", 32'(bus3.out_tile_idx));
            else check_output("out_tile_idx3", 32'(bus3.out_tile_idx), exp_tile3.pop_front());
        end
    end

    // Issue a one-cycle start pulse to the selected instance.
    task automatic apply_stimulus(input int sel, input logic [8:0] n, input logic [9:0] base);
        @(posedge clk);
        #1;
        if (sel == 1) begin
            bus1.cfg_num_tiles = n;
            bus1.cfg_bias_base = base;
            bus1.start         = 1'b1;
        end else begin
            bus3.cfg_num_tiles = n;
            bus3.cfg_bias_base = base;
            bus3.start         = 1'b1;
        end
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    task automatic queue_layer1(input logic [9:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr1.push_back(32'(10'(base + 10'(i))));
            exp_tile1.push_back(32'(i));
        end
    endtask

    task automatic clear_counts1();
        busy_cnt1 = 0;
        add_cnt1  = 0;
        done_cnt1 = 0;
        hs_cnt1   = 0;
        rd_cnt1   = 0;
    endtask

    task automatic wait_done(input int sel, input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if ((sel == 1) ? bus1.done : bus3.done) seen = 1'b1;
        end
        check_output(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_cond1(input int kind, input int tile, input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (kind == 0 && bus1.bias_rd_en && bus1.out_tile_idx == 9'(tile)) seen = 1'b1;
            if (kind == 1 && bus1.out_valid) seen = 1'b1;
        end
        check_output(name, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_busy"},         32'(bus1.busy),         32'd0);
        check_output({tag, "_done"},         32'(bus1.done),         32'd0);
        check_output({tag, "_bias_rd_en"},   32'(bus1.bias_rd_en),   32'd0);
        check_output({tag, "_bias_rd_addr"}, 32'(bus1.bias_rd_addr), 32'd0);
        check_output({tag, "_acc_ready"},    32'(bus1.acc_ready),    32'd0);
        check_output({tag, "_add_ena"},      32'(bus1.add_ena),      32'd0);
        check_output({tag, "_out_valid"},    32'(bus1.out_valid),    32'd0);
        check_output({tag, "_out_tile_idx"}, 32'(bus1.out_tile_idx), 32'd0);
`ifdef FC_BIAS_SCHED_PERF_EN
        check_output({tag, "_stall_cycles"}, bus1.stall_cycles,      32'd0);
`endif
    endtask

    // Hard stop if the sequence ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rstn = 1'b0;
        bus1.start = 1'b0; bus1.cfg_num_tiles = '0; bus1.cfg_bias_base = '0;
        bus1.acc_valid = 1'b0; bus1.out_ready = 1'b0;
        bus3.start = 1'b0; bus3.cfg_num_tiles = '0; bus3.cfg_bias_base = '0;
        bus3.acc_valid = 1'b0; bus3.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Basic four-tile layer with no stalls.
        bus1.acc_valid = 1'b1;
        bus1.out_ready = 1'b1;
        clear_counts1();
        queue_layer1(10'h010, 4);
        apply_stimulus(1, 9'd4, 10'h010);
        wait_done(1, 100, "basic_done_seen");
        @(negedge clk);
        check_output("basic_busy_cycles", 32'(busy_cnt1), 32'd16);
        check_output("basic_add_ena",     32'(add_cnt1),  32'd4);
        check_output("basic_handshakes",  32'(hs_cnt1),   32'd4);
        check_output("basic_done_pulses", 32'(done_cnt1), 32'd1);

        // Downstream backpressure on tile 2.
        clear_counts1();
        queue_layer1(10'h020, 4);
        apply_stimulus(1, 9'd4, 10'h020);
        wait_cond1(0, 2, 60, "bp_fetch_tile2");
        bus1.out_ready = 1'b0;
        wait_cond1(1, 0, 20, "bp_out_tile2");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check_output("bp_out_valid",    32'(bus1.out_valid),    32'd1);
            check_output("bp_add_ena",      32'(bus1.add_ena),      32'd0);
            check_output("bp_bias_rd_en",   32'(bus1.bias_rd_en),   32'd0);
            check_output("bp_out_tile_idx", 32'(bus1.out_tile_idx), 32'd2);
            @(posedge clk);
        end
        #1 bus1.out_ready = 1'b1;
        wait_done(1, 100, "bp_done_seen");
        @(negedge clk);
        check_output("bp_handshakes", 32'(hs_cnt1),  32'd4);
        check_output("bp_add_ena",    32'(add_cnt1), 32'd4);
`ifdef FC_BIAS_SCHED_PERF_EN
        check_output("bp_stall_cycles", bus1.stall_cycles, 32'd5);
`endif

        // Second start while busy must be ignored.
        clear_counts1();
        queue_layer1(10'h040, 2);
        apply_stimulus(1, 9'd2, 10'h040);
        repeat (2) @(posedge clk);
        apply_stimulus(1, 9'd7, 10'h099);
        wait_done(1, 100, "restart_done_seen");
        @(negedge clk);
        check_output("restart_handshakes",  32'(hs_cnt1),   32'd2);
        check_output("restart_done_pulses", 32'(done_cnt1), 32'd1);

        // Empty layer: done next cycle, no reads, never busy.
        clear_counts1();
        apply_stimulus(1, 9'd0, 10'h070);
        @(negedge clk);
        check_output("empty_done", 32'(bus1.done), 32'd1);
        check_output("empty_busy", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        check_output("empty_done_clears", 32'(bus1.done), 32'd0);
        check_output("empty_no_reads",    32'(rd_cnt1),    32'd0);
        check_output("empty_busy_cycles", 32'(busy_cnt1),  32'd0);

        // Bias address wraps modulo the address width.
        clear_counts1();
        queue_layer1(10'h3FE, 3);
        apply_stimulus(1, 9'd3, 10'h3FE);
        wait_done(1, 100, "wrap_done_seen");
        @(negedge clk);
        check_output("wrap_handshakes", 32'(hs_cnt1), 32'd3);

        // Reset while tile 1 is presented, then a fresh one-tile layer.
        exp_addr1.push_back(32'h050);
        exp_addr1.push_back(32'h051);
        exp_tile1.push_back(32'd0);
        apply_stimulus(1, 9'd3, 10'h050);
        wait_cond1(0, 1, 60, "rst_fetch_tile1");
        bus1.out_ready = 1'b0;
        wait_cond1(1, 0, 20, "rst_out_tile1");
        check_output("rst_tile_before", 32'(bus1.out_tile_idx), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus1.out_ready = 1'b1;
        clear_counts1();
        queue_layer1(10'h060, 1);
        apply_stimulus(1, 9'd1, 10'h060);
        wait_done(1, 100, "rst_new_done_seen");
        @(negedge clk);
        check_output("rst_new_handshakes", 32'(hs_cnt1),   32'd1);
        check_output("rst_new_done_pulse", 32'(done_cnt1), 32'd1);

        // Long bias latency with a late accumulator.
        bus3.acc_valid = 1'b0;
        bus3.out_ready = 1'b1;
        exp_addr3.push_back(32'h005);
        exp_tile3.push_back(32'd0);
        apply_stimulus(3, 9'd1, 10'h005);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus3.bias_rd_en) seen = 1'b1;
            end
            check_output("lat3_fetch_seen", 32'(seen), 32'd1);
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) bus3.acc_valid = 1'b1;
            if (c == 7) bus3.acc_valid = 1'b0;
            @(negedge clk);
            check_output($sformatf("lat3_acc_ready_c%0d", c), 32'(bus3.acc_ready), 32'(c >= 4 && c <= 6));
            check_output($sformatf("lat3_add_ena_c%0d", c),   32'(bus3.add_ena),   32'(c == 6));
            check_output($sformatf("lat3_out_valid_c%0d", c), 32'(bus3.out_valid), 32'(c == 7));
            check_output($sformatf("lat3_done_c%0d", c),      32'(bus3.done),      32'(c == 8));
        end
`ifdef FC_BIAS_SCHED_PERF_EN
        check_output("lat3_stall_cycles", bus3.stall_cycles, 32'd2);
`endif

        @(negedge clk);
        check_output("addr1_queue_drained", 32'(exp_addr1.size()), 32'd0);
        check_output("tile1_queue_drained", 32'(exp_tile1.size()), 32'd0);
        check_output("addr3_queue_drained", 32'(exp_addr3.size()), 32'd0);
        check_output("tile3_queue_drained", 32'(exp_tile3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fc_bias_add_sched.md
Name: fc_bias_add_sched

Overview:
- Sequencer for the fully-connected layer's bias-add stage: walks a layer's output neurons in tiles of LENGTH lanes.
- Per tile: issues a bias-memory read, accepts one accumulated vector from the MAC array (valid/ready), and pulses the add enable of the vector bias adder.
- Presents the registered sum downstream with valid/ready backpressure.
- Sits between the MAC accumulator output, the bias ROM/RAM and the activation stage; one instance per FC engine.

Parameters:
- LENGTH, 4, lanes per tile (informational; sets no logic width here)
- BIAS_RD_LAT, 1, bias memory read latency in cycles, legal range 1..7
- MAX_TILES, 256, maximum tiles per layer
- TILE_W, $clog2(MAX_TILES)+1, width of tile count/index
- BIAS_ADDR_W, 10, bias memory address width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  layer start pulse; sampled only in IDLE
- cfg_num_tiles  in  TILE_W  tiles in this layer; latched on start
- cfg_bias_base  in  BIAS_ADDR_W  bias address of tile 0; latched on start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at end of layer
- bias_rd_en  out  1  bias memory read strobe
- bias_rd_addr  out  BIAS_ADDR_W  bias read address
- acc_valid  in  1  accumulated vector valid
- acc_ready  out  1  scheduler can accept the accumulated vector
- add_ena  out  1  enable to the bias adder (adder registers on this cycle)
- out_valid  out  1  adder result valid downstream
- out_ready  in  1  downstream accepts result
- out_tile_idx  out  TILE_W  index of the tile currently presented/processed

Behaviour:
- Reset (rstn=0 at posedge, any state) → state IDLE. All outputs 0; tile_idx=0; latched cfg=0. Any in-flight tile is abandoned.
- States: IDLE, FETCH, WAIT_BIAS, WAIT_ACC, OUT.
- IDLE:
  - start=1 and cfg_num_tiles≠0 → latch cfg, tile_idx=0, go FETCH, busy=1 next cycle.
  - start=1 and cfg_num_tiles=0 → done pulses next cycle, stay IDLE, busy stays 0.
  - cfg_num_tiles>MAX_TILES is clamped to MAX_TILES.
- FETCH (1 cycle): bias_rd_en=1, bias_rd_addr=base+tile_idx (modulo 2^BIAS_ADDR_W); load lat_cnt=BIAS_RD_LAT; go WAIT_BIAS.
- WAIT_BIAS: lat_cnt decrements each cycle; at lat_cnt==1 go WAIT_ACC. The bias memory holds its data output until the next bias_rd_en.
- WAIT_ACC:
  - acc_ready=1 (registered).
  - add_ena = acc_valid & acc_ready (combinational).
  - On handshake go OUT. acc_valid arriving early is held off by acc_ready=0.
- OUT:
  - out_valid=1 (adder result is registered one cycle after add_ena, so valid coincides with the data).
  - Hold while out_ready=0; add_ena stays 0, so the result is stable.
  - On out_valid&out_ready:
    - if tile_idx==num_tiles-1 → done=1 for one cycle, busy=0, IDLE.
    - otherwise tile_idx+1, FETCH.
- out_tile_idx tracks tile_idx in every state.
- start while busy is ignored (no relatch, no error).
- Minimum per-tile latency with no stalls: 1 (FETCH) + BIAS_RD_LAT + 1 (accept) + 1 (output) cycles.

Optional Feature:
- Macro FC_BIAS_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cycles (32 bits), cleared on accepted start.
  - Increments every cycle in WAIT_ACC with acc_valid=0, or in OUT with out_ready=0. Saturates at all-ones.
  - Holds its value after done; reset clears it to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package fc_pkg holds:
  - enum fc_bias_state_e {IDLE, FETCH, WAIT_BIAS, WAIT_ACC, OUT}
  - default constants FC_LENGTH=4, FC_BIAS_ADDR_W=10, FC_MAX_TILES=256
- One natural sub-module, fc_lat_counter: loadable down-counter with a terminal flag, reused for WAIT_BIAS. Everything else stays in one FSM module.

Test Plan:
- Reset mid-layer: start with num_tiles=3, assert rstn=0 while in OUT of tile 1 → next cycle all outputs 0, state IDLE. A new start with num_tiles=1 then completes normally.
- Basic layer, BIAS_RD_LAT=1, base=0x10, num_tiles=4, acc_valid and out_ready always 1:
  - bias_rd_addr sequence 0x10, 0x11, 0x12, 0x13.
  - Exactly 4 add_ena pulses and 4 out handshakes, 4 cycles per tile.
  - done pulses once; busy high for exactly 16 cycles.
- Backpressure: out_ready=0 for 5 cycles on tile 2 → out_valid held, no add_ena, no bias_rd_en, out_tile_idx=2 stable; stall_cycles=5 when FC_BIAS_SCHED_PERF_EN is defined.
- Late accumulator plus long latency: BIAS_RD_LAT=3, acc_valid asserted 6 cycles after FETCH → acc_ready high from cycle 4 after FETCH; add_ena only in the cycle acc_valid rises.
- Edge configs:
  - num_tiles=0 → done pulse one cycle after start, no bias_rd_en.
  - start pulsed again mid-layer → ignored, tile count unchanged.
  - base=0x3FE with num_tiles=3 → addresses 0x3FE, 0x3FF, 0x000.
